// File: rtl/mux_pkg.sv
// Shared select-code type and code constants for the 8:1 mux.
package mux_pkg;

  typedef logic [2:0] sel_t;

  localparam sel_t SEL_R = 3'd0;
  localparam sel_t SEL_S = 3'd1;
  localparam sel_t SEL_T = 3'd2;
  localparam sel_t SEL_U = 3'd3;
  localparam sel_t SEL_V = 3'd4;
  localparam sel_t SEL_W = 3'd5;
  localparam sel_t SEL_X = 3'd6;
  localparam sel_t SEL_Y = 3'd7;

endpackage

// File: rtl/mux_2_to_1.sv
// WIDTH-bit 2:1 leaf mux; an unknown select yields X instead of quietly picking a side.
module mux_2_to_1 #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = {WIDTH{1'bx}};
    case (sel)
      1'b0:    y = a;
      1'b1:    y = b;
      default: y = {WIDTH{1'bx}};
    endcase
  end

endmodule

// File: rtl/mux_8_to_1.sv
// 8:1 mux built as a three-level tree of 2:1 muxes (S0, then S1, then S2).
// Define MUX_8_TO_1_REG_OUT_EN to register M (1-cycle latency, sync active-high reset).
module mux_8_to_1
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] R,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] T,
  input  logic [WIDTH-1:0] U,
  input  logic [WIDTH-1:0] V,
  input  logic [WIDTH-1:0] W,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] M,
  input  logic             S0,
  input  logic             S1,
  input  logic             S2,
  input  logic             clk,
  input  logic             reset
);

  sel_t             sel;
  logic [WIDTH-1:0] lvl0_rs, lvl0_tu, lvl0_vw, lvl0_xy;
  logic [WIDTH-1:0] lvl1_lo, lvl1_hi;
  logic [WIDTH-1:0] tree_out;

  assign sel = {S2, S1, S0};

  mux_2_to_1 #(.WIDTH(WIDTH)) u_mux_rs (.a(R), .b(S), .sel(sel[0]), .y(lvl0_rs));
  mux_2_to_1 #(.WIDTH(WIDTH)) u_mux_tu (.a(T), .b(U), .sel(sel[0]), .y(lvl0_tu));
  mux_2_to_1 #(.WIDTH(WIDTH)) u_mux_vw (.a(V), .b(W), .sel(sel[0]), .y(lvl0_vw));
  mux_2_to_1 #(.WIDTH(WIDTH)) u_mux_xy (.a(X), .b(Y), .sel(sel[0]), .y(lvl0_xy));

  mux_2_to_1 #(.WIDTH(WIDTH)) u_mux_lo (.a(lvl0_rs), .b(lvl0_tu), .sel(sel[1]), .y(lvl1_lo));
  mux_2_to_1 #(.WIDTH(WIDTH)) u_mux_hi (.a(lvl0_vw), .b(lvl0_xy), .sel(sel[1]), .y(lvl1_hi));

  mux_2_to_1 #(.WIDTH(WIDTH)) u_mux_top (.a(lvl1_lo), .b(lvl1_hi), .sel(sel[2]), .y(tree_out));

`ifdef MUX_8_TO_1_REG_OUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      M <= '0;
    end else begin
      M <= tree_out;
    end
  end
`else
  // clk and reset stay on the port list so both builds are pin-compatible.
  logic unused_clk_reset;
  assign unused_clk_reset = clk ^ reset;
  assign M = tree_out;
`endif

endmodule

// File: tb/tb_mux_8_to_1.sv
// Scoreboard bench for mux_8_to_1 (WIDTH=1 and WIDTH=16 instances); adapts to MUX_8_TO_1_REG_OUT_EN.
module tb_mux_8_to_1;
  import mux_pkg::*;

`ifdef MUX_8_TO_1_REG_OUT_EN
  localparam bit REG = 1'b1;
`else
  localparam bit REG = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              s0 = 1'b0, s1 = 1'b0, s2 = 1'b0;
  logic [7:0]        b1 = '0;
  logic [7:0][15:0]  w16 = '0;
  logic              m1;
  logic [15:0]       m16;

  always #5 clk = ~clk;

  mux_8_to_1 #(.WIDTH(1)) dut1 (
    .R(b1[0]), .S(b1[1]), .T(b1[2]), .U(b1[3]),
    .V(b1[4]), .W(b1[5]), .X(b1[6]), .Y(b1[7]),
    .M(m1), .S0(s0), .S1(s1), .S2(s2), .clk(clk), .reset(reset)
  );

  mux_8_to_1 #(.WIDTH(16)) dut16 (
    .R(w16[0]), .S(w16[1]), .T(w16[2]), .U(w16[3]),
    .V(w16[4]), .W(w16[5]), .X(w16[6]), .Y(w16[7]),
    .M(m16), .S0(s0), .S1(s1), .S2(s2), .clk(clk), .reset(reset)
  );

  typedef struct {
    int          due;
    logic        e1;
    logic [15:0] e16;
    string       nm;
  } exp_t;

  exp_t postq[$];
  exp_t preq[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input exp_t e, input string ph);
    n_cmp++;
    if (m1 !== e.e1) begin
      n_bad++;
      $display("FAIL %s/%s w1: got %b want %b", e.nm, ph, m1, e.e1);
    end
    n_cmp++;
    if (m16 !== e.e16) begin
      n_bad++;
      $display("FAIL %s/%s w16: got %h want %h", e.nm, ph, m16, e.e16);
    end
  endtask

  // Post-edge monitor: M must show the expectation pushed one negedge earlier.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      while (postq.size() > 0 && postq[0].due <= cyc) begin
        e = postq.pop_front();
        check(e, "post");
      end
    end
  end

  // Pre-edge monitor: M between the stimulus change and the next rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (preq.size() > 0 && preq[0].due <= cyc) begin
        e = preq.pop_front();
        check(e, "pre");
      end
    end
  end

  task automatic apply(input sel_t code, input logic [7:0] b, input logic [7:0][15:0] w,
                       input logic rst, input logic e1, input logic [15:0] e16,
                       input bit do_pre, input logic p1, input logic [15:0] p16,
                       input string nm);
    exp_t e;
    @(negedge clk);
    {s2, s1, s0} = code;
    b1 = b;
    w16 = w;
    reset = rst;
    if (do_pre) begin
      e = '{cyc, p1, p16, nm};
      preq.push_back(e);
    end
    e = '{cyc + 1, e1, e16, nm};
    postq.push_back(e);
  endtask

  localparam logic [7:0]       B34  = 8'b0101_1100;
  localparam logic [7:0][15:0] PAT  = {16'h0006, 16'h8001, 16'h1234, 16'hFF00,
                                       16'h00FF, 16'h3C3C, 16'hA5A5, 16'h0002};
  localparam logic [7:0][15:0] ONES = {8{16'hFFFF}};
  localparam logic [7:0][15:0] ZERO = '0;
  localparam logic [7:0][15:0] TONL = {16'h0000, 16'h0000, 16'h0000, 16'h0000,
                                       16'h0000, 16'hBEEF, 16'h0000, 16'h0000};
  localparam logic [7:0][15:0] RY   = {16'h0006, 16'h0000, 16'h0000, 16'h0000,
                                       16'h0000, 16'h0000, 16'h0000, 16'h0002};

  logic        e34_1  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [15:0] e34_16 [8] = '{16'h0002, 16'hA5A5, 16'h3C3C, 16'h00FF,
                              16'hFF00, 16'h1234, 16'h8001, 16'h0006};

  initial begin
    // Reset held with all-ones inputs: zeros when registered, pass-through otherwise.
    apply(3'd3, 8'hFF, ONES, 1'b1, REG ? 1'b0 : 1'b1, REG ? 16'h0000 : 16'hFFFF,
          1'b0, 1'b0, 16'h0, "rst_hold0");
    apply(3'd5, 8'hFF, ONES, 1'b1, REG ? 1'b0 : 1'b1, REG ? 16'h0000 : 16'hFFFF,
          1'b0, 1'b0, 16'h0, "rst_hold1");

    for (int i = 0; i < 8; i++)
      apply(sel_t'(i), B34, PAT, 1'b0, e34_1[i], e34_16[i],
            i == 0, 1'b0, REG ? 16'h0000 : 16'h0002, $sformatf("sweep34_%0d", i));

    for (int i = 0; i < 8; i++)
      apply(sel_t'(i), 8'h00, ZERO, 1'b0, 1'b0, 16'h0000,
            1'b0, 1'b0, 16'h0, $sformatf("zeros_%0d", i));

    for (int i = 0; i < 8; i++)
      apply(sel_t'(i), 8'hFF, ONES, 1'b0, 1'b1, 16'hFFFF,
            1'b0, 1'b0, 16'h0, $sformatf("ones_%0d", i));

    // Only T set; select moves 000 -> 010.
    apply(3'd0, 8'b0000_0100, TONL, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0, "t_pre");
    apply(3'd2, 8'b0000_0100, TONL, 1'b0, 1'b1, 16'hBEEF,
          1'b1, REG ? 1'b0 : 1'b1, REG ? 16'h0000 : 16'hBEEF, "t_sel");

    // Reset while M=1, hold, release.
    apply(3'd2, 8'b0000_0100, TONL, 1'b1, REG ? 1'b0 : 1'b1, REG ? 16'h0000 : 16'hBEEF,
          1'b1, 1'b1, 16'hBEEF, "rst_pri");
    apply(3'd2, 8'b0000_0100, TONL, 1'b1, REG ? 1'b0 : 1'b1, REG ? 16'h0000 : 16'hBEEF,
          1'b0, 1'b0, 16'h0, "rst_held");
    apply(3'd2, 8'b0000_0100, TONL, 1'b0, 1'b1, 16'hBEEF,
          1'b1, REG ? 1'b0 : 1'b1, REG ? 16'h0000 : 16'hBEEF, "rst_rel");

    // Wide R/Y pair.
    apply(3'd7, 8'b0000_0001, RY, 1'b0, 1'b0, 16'h0006, 1'b0, 1'b0, 16'h0, "wide_y");
    apply(3'd0, 8'b0000_0001, RY, 1'b0, 1'b1, 16'h0002,
          1'b1, REG ? 1'b0 : 1'b1, REG ? 16'h0006 : 16'h0002, "wide_r");

    repeat (3) @(negedge clk);
    n_cmp++;
    if (postq.size() + preq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", postq.size() + preq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
